baud_detect: RTL



---
 rtl/uart_pkg.sv | 58 +++++
 rtl/rx_sync.sv | 39 +++
 rtl/baud_detect.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART baud definitions: detector state type, baud select codes and
// the period/threshold helpers used by both the baud decoder and baud_detect.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_HIGH = 3'd1,
        ST_WAIT_FALL = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_DECODE    = 3'd4
    } bd_state_e;

    localparam logic [3:0] BAUD_300    = 4'h0;
    localparam logic [3:0] BAUD_1200   = 4'h1;
    localparam logic [3:0] BAUD_2400   = 4'h2;
    localparam logic [3:0] BAUD_4800   = 4'h3;
    localparam logic [3:0] BAUD_9600   = 4'h4;
    localparam logic [3:0] BAUD_19200  = 4'h5;
    localparam logic [3:0] BAUD_38400  = 4'h6;
    localparam logic [3:0] BAUD_57600  = 4'h7;
    localparam logic [3:0] BAUD_115200 = 4'h8;
    localparam logic [3:0] BAUD_230400 = 4'h9;
    localparam logic [3:0] BAUD_460800 = 4'hA;
    localparam logic [3:0] BAUD_921600 = 4'hB;

    function automatic int unsigned baud_rate(input logic [3:0] code);
        int unsigned rate;
        rate = 921600;
        case (code)
            BAUD_300:    rate = 300;
            BAUD_1200:   rate = 1200;
            BAUD_2400:   rate = 2400;
            BAUD_4800:   rate = 4800;
            BAUD_9600:   rate = 9600;
            BAUD_19200:  rate = 19200;
            BAUD_38400:  rate = 38400;
            BAUD_57600:  rate = 57600;
            BAUD_115200: rate = 115200;
            BAUD_230400: rate = 230400;
            BAUD_460800: rate = 460800;
            default:     rate = 921600;
        endcase
        return rate;
    endfunction

    // Bit period in clock cycles for a baud code.
    function automatic int unsigned baud_period(input int unsigned clk_freq,
                                                input logic [3:0]  code);
        return clk_freq / baud_rate(code);
    endfunction

    // Decision point halfway between the periods of code and code+1.
    function automatic int unsigned baud_mid(input int unsigned clk_freq,
                                             input logic [3:0]  code);
        return (baud_period(clk_freq, code) + baud_period(clk_freq, code + 4'd1)) / 2;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// rx line synchronizer; BAUD_DETECT_GLITCH_FILTER_EN adds a 3-sample
// majority filter after the 2-FF chain (one extra cycle of latency).
module rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic rx,
    output logic rxs
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb sync_d = {sync_q[0], rx};

    always_ff @(posedge clk) begin
        if (!reset_n) sync_q <= 2'b11;
        else          sync_q <= sync_d;
    end

`ifdef BAUD_DETECT_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic [1:0] hist_d;

    always_comb hist_d = {hist_q[0], sync_q[1]};

    always_ff @(posedge clk) begin
        if (!reset_n) hist_q <= 2'b11;
        else          hist_q <= hist_d;
    end

    // Majority of the current and two previous synchronized samples.
    assign rxs = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign rxs = sync_q[1];
`endif

endmodule

// File: rtl/baud_detect.sv
// Auto-baud detector: measures the start bit of a 0x55 sync character and
// encodes it as a baud code. Optional filter: BAUD_DETECT_GLITCH_FILTER_EN.
module baud_detect
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned CNT_W    = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       arm,
    output logic [3:0] baud,
    output logic       baud_valid,
    output logic       done,
    output logic       err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(2 * (CLK_FREQ / 300));
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'((CLK_FREQ / 921600) / 2);

    logic rxs;

    rx_sync u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .rxs     (rxs)
    );

    bd_state_e        state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [3:0]       baud_q, baud_d;
    logic             baud_valid_q, baud_valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // at_least[n] is set when the measured width reaches the code-n threshold;
    // thresholds fall with n so the lowest set bit is the code.
    logic [10:0] at_least;
    logic [3:0]  decoded_code;

    genvar gi;
    generate
        for (gi = 0; gi < 11; gi++) begin : g_thresh
            localparam logic [CNT_W-1:0] MID = CNT_W'(baud_mid(CLK_FREQ, 4'(gi)));
            assign at_least[gi] = (counter_q >= MID);
        end
    endgenerate

    always_comb begin
        decoded_code = BAUD_921600;
        for (int i = 10; i >= 0; i--) begin
            if (at_least[i]) decoded_code = 4'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        baud_d       = baud_q;
        baud_valid_d = baud_valid_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) state_d = ST_WAIT_HIGH;
            end
            ST_WAIT_HIGH: begin
                if (rxs) state_d = ST_WAIT_FALL;
            end
            ST_WAIT_FALL: begin
                if (!rxs) begin
                    counter_d = CNT_W'(1);
                    state_d   = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (rxs) begin
                    // Too-short low pulses are rejected but detection stays armed.
                    if (counter_q < MIN_CNT) begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT_FALL;
                    end else begin
                        state_d = ST_DECODE;
                    end
                end else if (counter_q >= TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                baud_d       = decoded_code;
                baud_valid_d = 1'b1;
                done_d       = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            counter_q    <= '0;
            baud_q       <= 4'h0;
            baud_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            baud_q       <= baud_d;
            baud_valid_q <= baud_valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign baud       = baud_q;
    assign baud_valid = baud_valid_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
